// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: scoreboard state encoding, bubble select constant and register-match helper
package hazard_stall_unit_pkg;
  typedef enum logic [1:0] {MC_IDLE = 2'd0, MC_BUSY = 2'd1, MC_DONE = 2'd2} mc_state_e;
  // ID/EX mux select value that loads the NOP bubble
  localparam logic IDEX_NOP_SEL = 1'b1;
  // int x0 is hardwired and never matches; float f0 is a real register
  function automatic logic reg_match(logic [4:0] s, logic s_f, logic [4:0] d, logic d_wi, logic d_wf);
    return s_f ? (d_wf && s == d) : (d_wi && s != 5'd0 && s == d);
  endfunction
endpackage

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: ID/EX hazard inputs and stall/scoreboard outputs; master drives, slave is the unit
interface hazard_stall_unit_if;
  logic [4:0] ID_Rs1, ID_Rs2, ID_frs3, ID_Rd, EX_Rd, mc_rd;
  logic ID_use_rs1, ID_use_rs2, ID_use_rs3, ID_f_rs1, ID_f_rs2;
  logic ID_f_RegWrite, ID_multicycle, ID_flush;
  logic EX_MemRead, EX_RegWrite, EX_f_RegWrite;
  logic PC_stall, IFID_stall, IDEX_bubble, mc_busy, mc_done;
  modport master (
    output ID_Rs1, ID_Rs2, ID_frs3, ID_use_rs1, ID_use_rs2, ID_use_rs3, ID_f_rs1, ID_f_rs2,
           ID_Rd, ID_f_RegWrite, ID_multicycle, ID_flush, EX_MemRead, EX_RegWrite, EX_f_RegWrite, EX_Rd,
    input  PC_stall, IFID_stall, IDEX_bubble, mc_busy, mc_done, mc_rd
  );
  modport slave (
    input  ID_Rs1, ID_Rs2, ID_frs3, ID_use_rs1, ID_use_rs2, ID_use_rs3, ID_f_rs1, ID_f_rs2,
           ID_Rd, ID_f_RegWrite, ID_multicycle, ID_flush, EX_MemRead, EX_RegWrite, EX_f_RegWrite, EX_Rd,
    output PC_stall, IFID_stall, IDEX_bubble, mc_busy, mc_done, mc_rd
  );
endinterface

// File: rtl/hazard_stall_unit_mc_scoreboard.sv
// hazard_stall_unit_mc_scoreboard: one outstanding iterative FPU op; ports clk, reset, issue_i, rd_i -> state_o, rd_o
module hazard_stall_unit_mc_scoreboard
  import hazard_stall_unit_pkg::*;
#(
  parameter int MC_LAT = 16,
  parameter int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_i,
  input  logic [4:0] rd_i,
  output mc_state_e  state_o,
  output logic [4:0] rd_o
);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(MC_LAT - 1);
  mc_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0] rd_q;
  // BUSY lasts MC_LAT cycles (count LOAD..0), then one DONE writeback cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MC_IDLE;
      cnt_q <= '0;
      rd_q <= '0;
    end else begin
      case (state_q)
        MC_IDLE, MC_DONE: begin
          if (issue_i) begin
            state_q <= MC_BUSY;
            cnt_q <= LOAD;
            rd_q <= rd_i;
          end else begin
            state_q <= MC_IDLE;
          end
        end
        MC_BUSY: begin
          if (cnt_q == '0) state_q <= MC_DONE;
          else cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= MC_IDLE;
      endcase
    end
  end
  assign state_o = state_q;
  assign rd_o = rd_q;
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage load-use and long-latency FPU hazard stall; ports clk, reset, bus (slave)
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MC_LAT = 16,
  parameter int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1
) (
  input logic clk,
  input logic reset,
  hazard_stall_unit_if.slave bus
);
  mc_state_e state;
  logic [4:0] mc_rd;
  logic busy, load_use, mc_raw, mc_waw, mc_struct, stall, issue;
  hazard_stall_unit_mc_scoreboard #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) u_sb (
    .clk(clk), .reset(reset), .issue_i(issue), .rd_i(bus.ID_Rd), .state_o(state), .rd_o(mc_rd)
  );
  assign busy = state != MC_IDLE;
  assign load_use = bus.EX_MemRead & (
      (bus.ID_use_rs1 & reg_match(bus.ID_Rs1, bus.ID_f_rs1, bus.EX_Rd, bus.EX_RegWrite, bus.EX_f_RegWrite)) |
      (bus.ID_use_rs2 & reg_match(bus.ID_Rs2, bus.ID_f_rs2, bus.EX_Rd, bus.EX_RegWrite, bus.EX_f_RegWrite)) |
      (bus.ID_use_rs3 & reg_match(bus.ID_frs3, 1'b1, bus.EX_Rd, bus.EX_RegWrite, bus.EX_f_RegWrite)));
  // the pending op only writes the float file, so int sources can never hit it
  assign mc_raw = busy & (
      (bus.ID_use_rs1 & reg_match(bus.ID_Rs1, bus.ID_f_rs1, mc_rd, 1'b0, 1'b1)) |
      (bus.ID_use_rs2 & reg_match(bus.ID_Rs2, bus.ID_f_rs2, mc_rd, 1'b0, 1'b1)) |
      (bus.ID_use_rs3 & reg_match(bus.ID_frs3, 1'b1, mc_rd, 1'b0, 1'b1)));
  assign mc_waw = busy & bus.ID_f_RegWrite & (bus.ID_Rd == mc_rd);
  // DONE frees the iterative unit, so a new op may issue in that cycle
  assign mc_struct = bus.ID_multicycle & (state == MC_BUSY);
  assign stall = (load_use | mc_raw | mc_waw | mc_struct) & ~bus.ID_flush;
  assign issue = bus.ID_multicycle & ~stall & ~bus.ID_flush;
  assign bus.PC_stall = stall;
  assign bus.IFID_stall = stall;
  assign bus.IDEX_bubble = stall ? IDEX_NOP_SEL : ~IDEX_NOP_SEL;
  assign bus.mc_busy = busy;
  assign bus.mc_done = state == MC_DONE;
  assign bus.mc_rd = mc_rd;
endmodule
